// File: rtl/ssp_pkg.sv
// ---------------------------------------------------------------------------
// ssp_pkg
// Shared definitions for the SSP receive-side controller:
//   SSP_DW    - default data width
//   SSP_DEPTH - default receive FIFO depth (power of 2)
//   SSP_AW    - default FIFO pointer width, log2(SSP_DEPTH)
//   rd_state_e - read-handshake FSM encoding (IDLE=0, HOLD=1)
// ---------------------------------------------------------------------------
package ssp_pkg;

  localparam int SSP_DW    = 8;
  localparam int SSP_DEPTH = 4;
  localparam int SSP_AW    = 2;

  typedef enum logic {
    IDLE = 1'b0,  // waiting for a read select
    HOLD = 1'b1   // read taken; wait for PSEL to drop
  } rd_state_e;

endpackage : ssp_pkg

// File: rtl/ssp_rx_ctrl_if.sv
// ---------------------------------------------------------------------------
// ssp_rx_ctrl_if
// Bundles the APB-style read port, the serial-receiver push port and the
// status outputs of ssp_rx_ctrl.
//   master modport: drives PSEL, PWRITE, rx_wr_strobe, rx_data;
//                   observes PRDATA and status.
//   slave modport : the controller; the reverse directions.
// ---------------------------------------------------------------------------
interface ssp_rx_ctrl_if #(
  parameter int DW = ssp_pkg::SSP_DW,
  parameter int AW = ssp_pkg::SSP_AW
);

  logic          PSEL;
  logic          PWRITE;
  logic          rx_wr_strobe;
  logic [DW-1:0] rx_data;
  logic [DW-1:0] PRDATA;
  logic          rx_fifo_full;
  logic          SSPRXINTR;
  logic          rx_empty;
  logic          rx_overrun;
  logic [AW:0]   rx_count;

  modport master (
    output PSEL, PWRITE, rx_wr_strobe, rx_data,
    input  PRDATA, rx_fifo_full, SSPRXINTR, rx_empty, rx_overrun, rx_count
  );

  modport slave (
    input  PSEL, PWRITE, rx_wr_strobe, rx_data,
    output PRDATA, rx_fifo_full, SSPRXINTR, rx_empty, rx_overrun, rx_count
  );

endinterface : ssp_rx_ctrl_if

// File: rtl/ssp_sync_fifo.sv
// ---------------------------------------------------------------------------
// ssp_sync_fifo
// Single-clock FIFO: storage, read/write pointers and occupancy count.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   push, wr_data    - store wr_data at the tail (caller guarantees room,
//                      or a simultaneous pop when full)
//   pop, rd_data     - rd_data always shows the head; pop advances it
//   count            - occupancy, 0..DEPTH
//   full, empty      - decoded from count
// ---------------------------------------------------------------------------
module ssp_sync_fifo
  import ssp_pkg::*;
#(
  parameter int DW    = SSP_DW,
  parameter int DEPTH = SSP_DEPTH,
  parameter int AW    = SSP_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are AW bits and wrap from DEPTH-1 to 0 on their own.
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; the count and pointers
  // define what is valid, and a resettable array costs a reset tree per bit.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  // When full, a push and pop share one slot; the head is read before the
  // write lands, so the popped byte is the old one.
  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;
  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);

endmodule : ssp_sync_fifo

// File: rtl/ssp_rx_ctrl.sv
// ---------------------------------------------------------------------------
// ssp_rx_ctrl
// Receive-side controller of the SSP block (PCLK domain). Turns each rising
// edge of rx_wr_strobe into one FIFO push, serves one pop per PSEL read
// assertion into the registered PRDATA, and tracks a sticky overrun flag.
// Ports:
//   PCLK  - clock, rising edge
//   CLEAR - asynchronous active-high reset
//   bus   - ssp_rx_ctrl_if.slave: PSEL/PWRITE/PRDATA read port,
//           rx_wr_strobe/rx_data push port, rx_fifo_full, SSPRXINTR,
//           rx_empty, rx_overrun, rx_count status
// ---------------------------------------------------------------------------
module ssp_rx_ctrl
  import ssp_pkg::*;
#(
  parameter int DW    = SSP_DW,
  parameter int DEPTH = SSP_DEPTH,
  parameter int AW    = SSP_AW
) (
  input  logic          PCLK,
  input  logic          CLEAR,
  ssp_rx_ctrl_if.slave  bus
);

  logic          strobe_q,  strobe_d;
  rd_state_e     state_q,   state_d;
  logic [DW-1:0] prdata_q,  prdata_d;
  logic          overrun_q, overrun_d;

  logic          push_evt, rd_req, pop, push;
  logic          full, empty;
  logic [DW-1:0] head;
  logic [AW:0]   count;

  assign push_evt = bus.rx_wr_strobe & ~strobe_q;
  // Only the first cycle of a read select counts; HOLD absorbs the rest.
  assign rd_req   = (state_q == IDLE) & bus.PSEL & ~bus.PWRITE;
  assign pop      = rd_req & ~empty;
  // A push into a full FIFO is still accepted if a pop frees the slot now.
  assign push     = push_evt & (~full | pop);

  always_comb begin
    strobe_d  = bus.rx_wr_strobe;
    state_d   = state_q;
    prdata_d  = prdata_q;
    overrun_d = overrun_q;

    unique case (state_q)
      IDLE: if (rd_req) begin
        state_d  = HOLD;
        prdata_d = empty ? '0 : head;
      end
      HOLD: if (!bus.PSEL) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Clear has priority over set.
    if (pop)                   overrun_d = 1'b0;
    else if (push_evt && full) overrun_d = 1'b1;
  end

  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      strobe_q  <= 1'b0;
      state_q   <= IDLE;
      prdata_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      strobe_q  <= strobe_d;
      state_q   <= state_d;
      prdata_q  <= prdata_d;
      overrun_q <= overrun_d;
    end
  end

  ssp_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (PCLK),
    .rst     (CLEAR),
    .push    (push),
    .pop     (pop),
    .wr_data (bus.rx_data),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign bus.PRDATA       = prdata_q;
  assign bus.rx_fifo_full = full;
  assign bus.SSPRXINTR    = full;
  assign bus.rx_empty     = empty;
  assign bus.rx_overrun   = overrun_q;
  assign bus.rx_count     = count;

endmodule : ssp_rx_ctrl

// File: tb/tb_ssp_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ssp_rx_ctrl
// Directed bench for ssp_rx_ctrl. Inputs change just after the falling edge
// of PCLK; outputs are sampled at the same point, half a cycle after the
// rising edge that updated them.
// ---------------------------------------------------------------------------
module tb_ssp_rx_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;

  logic PCLK  = 1'b0;
  logic CLEAR = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  ssp_rx_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  ssp_rx_ctrl #(.DW(DW), .DEPTH(4), .AW(AW)) dut (
    .PCLK  (PCLK),
    .CLEAR (CLEAR),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge PCLK);
  endtask

  // Strobe high for two cycles (one edge), then low for one.
  task automatic push(input logic [7:0] b);
    bus.rx_data      = b;
    bus.rx_wr_strobe = 1'b1;
    step(2);
    bus.rx_wr_strobe = 1'b0;
    step();
  endtask

  // One-cycle read select followed by one idle cycle.
  task automatic read();
    bus.PSEL   = 1'b1;
    bus.PWRITE = 1'b0;
    step();
    bus.PSEL   = 1'b0;
    step();
  endtask

  task automatic read_expect(input string tag, input logic [7:0] exp);
    read();
    check(tag, bus.PRDATA, exp);
  endtask

  initial begin
    bus.PSEL         = 1'b0;
    bus.PWRITE       = 1'b0;
    bus.rx_wr_strobe = 1'b0;
    bus.rx_data      = '0;

    // Reset values
    step(2);
    check("rst_prdata", bus.PRDATA, 0);
    check("rst_count", bus.rx_count, 0);
    check("rst_empty", bus.rx_empty, 1);
    check("rst_full", bus.rx_fifo_full, 0);
    check("rst_intr", bus.SSPRXINTR, 0);
    check("rst_ovr", bus.rx_overrun, 0);
    CLEAR = 1'b0;
    step();

    // Single byte
    push(8'hA5);
    check("single_count", bus.rx_count, 1);
    check("single_empty", bus.rx_empty, 0);
    read_expect("single_data", 8'hA5);
    check("single_count0", bus.rx_count, 0);
    check("single_empty1", bus.rx_empty, 1);

    // Fill and overrun
    for (int i = 1; i <= 4; i++) push(8'(i));
    check("fill_count", bus.rx_count, 4);
    check("fill_full", bus.rx_fifo_full, 1);
    check("fill_intr", bus.SSPRXINTR, 1);
    check("fill_ovr0", bus.rx_overrun, 0);
    push(8'h05);
    check("ovr_set", bus.rx_overrun, 1);
    check("ovr_count", bus.rx_count, 4);
    read_expect("ovr_rd0", 8'h01);
    check("ovr_clr", bus.rx_overrun, 0);
    check("ovr_notfull", bus.rx_fifo_full, 0);
    read_expect("ovr_rd1", 8'h02);
    read_expect("ovr_rd2", 8'h03);
    read_expect("ovr_rd3", 8'h04);
    check("ovr_count0", bus.rx_count, 0);

    // Wrap-around
    for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i));
    for (int i = 0; i < 3; i++) read_expect("wrap_c", 8'hC0 + 8'(i));
    for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
    check("wrap_full", bus.rx_fifo_full, 1);
    for (int i = 0; i < 4; i++) read_expect("wrap_b", 8'hB0 + 8'(i));
    check("wrap_count0", bus.rx_count, 0);

    // Full + push edge + pop in the same cycle
    for (int i = 0; i < 4; i++) push(8'hD0 + 8'(i));
    bus.rx_data      = 8'hD4;
    bus.rx_wr_strobe = 1'b1;
    bus.PSEL         = 1'b1;
    bus.PWRITE       = 1'b0;
    step();
    bus.PSEL = 1'b0;
    step();
    bus.rx_wr_strobe = 1'b0;
    step();
    check("sim_data", bus.PRDATA, 8'hD0);
    check("sim_count", bus.rx_count, 4);
    check("sim_ovr", bus.rx_overrun, 0);
    check("sim_full", bus.rx_fifo_full, 1);
    for (int i = 1; i <= 4; i++) read_expect("sim_drain", 8'hD0 + 8'(i));
    check("sim_count0", bus.rx_count, 0);

    // Empty + push edge + read in the same cycle: no bypass
    bus.rx_data      = 8'h3C;
    bus.rx_wr_strobe = 1'b1;
    bus.PSEL         = 1'b1;
    step();
    bus.PSEL = 1'b0;
    step();
    bus.rx_wr_strobe = 1'b0;
    step();
    check("byp_data", bus.PRDATA, 8'h00);
    check("byp_count", bus.rx_count, 1);
    read_expect("byp_stored", 8'h3C);

    // Long read select: exactly one pop
    push(8'hE0);
    push(8'hE1);
    bus.PSEL   = 1'b1;
    bus.PWRITE = 1'b0;
    step(6);
    bus.PSEL = 1'b0;
    step();
    check("hold_data", bus.PRDATA, 8'hE0);
    check("hold_count", bus.rx_count, 1);
    read_expect("hold_next", 8'hE1);

    // Read while empty; next push must be returned (pointers untouched)
    read_expect("empty_data", 8'h00);
    check("empty_count", bus.rx_count, 0);
    check("empty_flag", bus.rx_empty, 1);
    push(8'hF0);
    read_expect("empty_ptr", 8'hF0);

    // Write access: no pop, PRDATA holds
    push(8'h77);
    bus.PSEL   = 1'b1;
    bus.PWRITE = 1'b1;
    step();
    bus.PSEL   = 1'b0;
    bus.PWRITE = 1'b0;
    step();
    check("wr_prdata", bus.PRDATA, 8'hF0);
    check("wr_count", bus.rx_count, 1);
    read_expect("wr_data", 8'h77);

    // Reset mid-fill with strobe held high through deassertion
    for (int i = 0; i < 3; i++) push(8'h60 + 8'(i));
    check("mid_count3", bus.rx_count, 3);
    read_expect("mid_pre", 8'h60);
    bus.rx_data      = 8'h99;
    bus.rx_wr_strobe = 1'b1;
    step();
    #1 CLEAR = 1'b1;
    #1;
    check("mid_count", bus.rx_count, 0);
    check("mid_empty", bus.rx_empty, 1);
    check("mid_prdata", bus.PRDATA, 0);
    step();
    CLEAR = 1'b0;
    step(2);
    check("mid_repush", bus.rx_count, 1);
    bus.rx_wr_strobe = 1'b0;
    step();
    read_expect("mid_data", 8'h99);
    check("mid_end", bus.rx_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ssp_rx_ctrl
